// File: rtl/decimal_to_bcd_encoder.sv
// decimal_to_bcd_encoder
// Turns 10 one-hot decimal key lines into one debounced BCD digit per
// keypress. The digit is presented on a valid/ready handshake and feeds the
// BCD bus of the downstream BCD-to-decimal decoder.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   key[9:0]   decimal key lines, bit n = digit n pressed (asynchronous)
//   bcd[3:0]   encoded digit 0..9, holds its last value after transfer
//   bcd_valid  bcd holds an accepted digit
//   bcd_ready  consumer takes bcd when high together with bcd_valid
//   busy       FSM is not in IDLE
//   key_err    one-cycle pulse on a rejected multi-key press
//
// Optional feature: define BCD_MULTIKEY_ERR_EN to reject presses with more
// than one key down (key_err pulse, no digit). Without it key_err is 0 and
// the highest pressed digit wins.
module decimal_to_bcd_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] key,
   output logic [3:0] bcd,
   output logic       bcd_valid,
   input  logic       bcd_ready,
   output logic       busy,
   output logic       key_err
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      EMIT,
      WAIT_RELEASE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [9:0]       snap;
   logic [9:0]       sync_q [SYNC_STAGES];
   logic [9:0]       key_s;

   // Highest set index wins, so the result is always 0..9.
   function automatic logic [3:0] encode(input logic [9:0] v);
      logic [3:0] e;
      e = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (v[i]) e = 4'(i);
      end
      return e;
   endfunction

   // Synchroniser chain on every key line.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 10'd0;
      end else begin
         sync_q[0] <= key;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign key_s = sync_q[SYNC_STAGES-1];

   // Press/debounce/emit/release FSM. busy is updated alongside every state
   // change so it always mirrors the state actually held.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         snap      <= 10'd0;
         bcd       <= 4'd0;
         bcd_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef BCD_MULTIKEY_ERR_EN
         key_err   <= 1'b0;
`endif
      end else begin
`ifdef BCD_MULTIKEY_ERR_EN
         key_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (key_s != 10'd0) begin
                  snap  <= key_s;
                  cnt   <= '0;
                  state <= DEBOUNCE;
                  busy  <= 1'b1;
               end
            end
            DEBOUNCE: begin
               if (key_s != snap) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
`ifdef BCD_MULTIKEY_ERR_EN
                  if ($countones(snap) > 1) begin
                     key_err <= 1'b1;
                     cnt     <= '0;
                     state   <= WAIT_RELEASE;
                  end else begin
                     bcd       <= encode(snap);
                     bcd_valid <= 1'b1;
                     state     <= EMIT;
                  end
`else
                  bcd       <= encode(snap);
                  bcd_valid <= 1'b1;
                  state     <= EMIT;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            EMIT: begin
               // Digit is committed: key activity here is ignored.
               if (bcd_valid && bcd_ready) begin
                  bcd_valid <= 1'b0;
                  cnt       <= '0;
                  state     <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (key_s != 10'd0) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifndef BCD_MULTIKEY_ERR_EN
   assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_decimal_to_bcd_encoder.sv
// Directed self-checking bench for decimal_to_bcd_encoder at default
// parameters (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, latency 7 edges).
module tb_decimal_to_bcd_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] key;
   logic [3:0] bcd;
   logic       bcd_valid;
   logic       bcd_ready;
   logic       busy;
   logic       key_err;

   int n_cmp = 0;
   int n_err = 0;

   decimal_to_bcd_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .bcd       (bcd),
      .bcd_valid (bcd_valid),
      .bcd_ready (bcd_ready),
      .busy      (busy),
      .key_err   (key_err)
   );

   always #5 clk = ~clk;

   // One rising edge; inputs change and outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Ticks until bcd_valid is seen or max edges pass; n = edges taken.
   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (n < max && bcd_valid !== 1'b1) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int cnt_v;
      int cnt_e;
      logic stable;

      // Reset held for 3 edges with a key down.
      rst = 1'b1; key = 10'h004; bcd_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_bcd", 32'(bcd), 32'd0);
         chk("rst_valid", 32'(bcd_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      rst = 1'b0;
      tick(); tick();
      chk("busy_pre", 32'(busy), 32'd0);
      tick();
      chk("busy_rise", 32'(busy), 32'd1);
      bcd_ready = 1'b1;
      wait_valid(20, n);
      chk("post_rst_lat", 32'(n), 32'd4);
      chk("post_rst_bcd", 32'(bcd), 32'd2);
      key = 10'h000;
      for (int i = 0; i < 10; i++) tick();
      chk("post_rst_idle", 32'(busy), 32'd0);

      // Single press with ready held high.
      key = 10'h020;
      wait_valid(20, n);
      chk("single_lat", 32'(n), 32'd7);
      chk("single_bcd", 32'(bcd), 32'd5);
      tick();
      chk("single_drop", 32'(bcd_valid), 32'd0);
      chk("single_hold_bcd", 32'(bcd), 32'd5);
      cnt_v = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bcd_valid) cnt_v++;
      end
      chk("single_no_repeat", 32'(cnt_v), 32'd0);
      key = 10'h000;
      for (int i = 0; i < 5; i++) tick();
      chk("release_busy5", 32'(busy), 32'd1);
      tick();
      chk("release_busy6", 32'(busy), 32'd0);

      // Bouncing contact never produces a digit, steady contact gives one.
      cnt_v = 0;
      for (int i = 0; i < 5; i++) begin
         key = 10'h100; tick(); if (bcd_valid) cnt_v++;
         tick(); if (bcd_valid) cnt_v++;
         key = 10'h000; tick(); if (bcd_valid) cnt_v++;
         tick(); if (bcd_valid) cnt_v++;
      end
      chk("bounce_quiet", 32'(cnt_v), 32'd0);
      key = 10'h100;
      wait_valid(20, n);
      chk("bounce_emit", 32'(bcd_valid), 32'd1);
      chk("bounce_bcd", 32'(bcd), 32'd8);
      cnt_v = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bcd_valid) cnt_v++;
      end
      chk("bounce_once", 32'(cnt_v), 32'd0);
      key = 10'h000;
      for (int i = 0; i < 8; i++) tick();
      chk("bounce_idle", 32'(busy), 32'd0);

      // Backpressure: digit stays put while ready is low, key released.
      bcd_ready = 1'b0;
      key = 10'h200;
      wait_valid(20, n);
      chk("bp_lat", 32'(n), 32'd7);
      chk("bp_bcd", 32'(bcd), 32'd9);
      key = 10'h000;
      stable = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bcd_valid !== 1'b1 || bcd !== 4'd9) stable = 1'b0;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      bcd_ready = 1'b1;
      tick();
      chk("bp_drop", 32'(bcd_valid), 32'd0);
      chk("bp_keep_bcd", 32'(bcd), 32'd9);
      tick(); tick(); tick();
      chk("bp_busy3", 32'(busy), 32'd1);
      tick();
      chk("bp_idle", 32'(busy), 32'd0);

      // Multi-key press 3 and 7.
      key = 10'h088;
      cnt_v = 0; cnt_e = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (bcd_valid) begin
            cnt_v++;
            chk("multi_bcd", 32'(bcd), 32'd7);
         end
         if (key_err) cnt_e++;
      end
`ifdef BCD_MULTIKEY_ERR_EN
      chk("multi_valid", 32'(cnt_v), 32'd0);
      chk("multi_err_pulse", 32'(cnt_e), 32'd1);
`else
      chk("multi_valid", 32'(cnt_v), 32'd1);
      chk("multi_err", 32'(cnt_e), 32'd0);
`endif
      key = 10'h000;
      for (int i = 0; i < 8; i++) tick();
      chk("multi_idle", 32'(busy), 32'd0);

      // Reset while a digit is pending.
      bcd_ready = 1'b0;
      key = 10'h010;
      wait_valid(20, n);
      chk("mid_valid", 32'(bcd_valid), 32'd1);
      chk("mid_bcd", 32'(bcd), 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(bcd_valid), 32'd0);
      chk("mid_rst_bcd", 32'(bcd), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      wait_valid(20, n);
      chk("mid_relat", 32'(n), 32'd7);
      chk("mid_rebcd", 32'(bcd), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
